branch_hazard_ctrl: RTL
=======================

// Module: branch_hazard_ctrl
// PURPOSE
//  ID-stage stall/flush controller for early branch resolution, the counterpart to the branch
//  forwarding mux select. Forwarding picks where a branch operand comes from; this block stalls
//  the branch in ID until that operand exists on a forwarding path. It also flushes IF/ID when a
//  resolved branch is taken. Sits beside the ID-stage comparator; drives PC, IF/ID and ID/EX control.
// PARAMETERS
//  CNT_W   32  width of the stall-cycle performance counter
// PORTS
//  clk            in   1      clock; all state updates on the rising edge
//  rst_n          in   1      asynchronous, active-low reset
//  ID_isbranch    in   1      ID instruction compares operands (beq/bne/jr)
//  ID_usert       in   1      branch also reads rt (0 for jr/bgez-type)
//  rs, rt         in   5      ID source register numbers
//  EXwbadd        in   5      EX-stage destination register
//  EXregwrite     in   1      EX instruction writes a register
//  EXmemread      in   1      EX instruction is a load
//  MEMwbadd       in   5      MEM-stage destination register
//  MEMregwrite    in   1      MEM instruction writes a register
//  MEMmemread     in   1      MEM instruction is a load
//  branch_taken   in   1      ID comparator result (valid only when no stall)
//  pc_write       out  1      1 = PC may update
//  ifid_write     out  1      1 = IF/ID register may update
//  idex_bubble    out  1      1 = insert NOP into ID/EX
//  ifid_flush     out  1      1 = squash the IF/ID instruction (taken branch)
//  stall_cycles   out  CNT_W  saturating count of stalled cycles since reset
// BEHAVIOUR
//  Reset (async, rst_n=0): state=RUN, cnt=0, stall_cycles=0.
//   Outputs during reset: pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0.
//  Per-operand need (0..2), evaluated only when ID_isbranch=1; rt counts only if ID_usert=1.
//   A match requires reg!=0 and a matching regwrite.
//   EX match & EXmemread -> 2; EX match, not load -> 1; MEM match & MEMmemread -> 1; else 0.
//   EX match takes priority over MEM match. need = max(need_rs, need_rt).
//  FSM states: RUN, STALL.
//   RUN, need=0: no stall; ifid_flush = ID_isbranch & branch_taken (combinational, same cycle).
//   RUN, need>0: stall asserted this cycle. cnt <= need-1.
//    next = (need==2) ? STALL : RUN.
//   STALL: stall asserted and hazard inputs ignored. cnt decrements; at cnt==1 next=RUN.
//   The RUN state re-evaluates the hazard on its next cycle.
//  stall = (state==STALL) | (state==RUN & need>0). Outputs during stall:
//   pc_write=0, ifid_write=0, idex_bubble=1.
//  ifid_flush is forced 0 whenever stall=1. Hazard wins over taken; the branch resolves later.
//  Max stall per branch = 2 cycles (load in EX). Stall outputs are combinational from state and
//   inputs; state, cnt and stall_cycles are registered.
//  stall_cycles: +1 on each clock edge with stall=1; saturates at all-ones (no wrap).
//  Async reset mid-STALL: immediate return to RUN, outputs to reset values, counter cleared.
//  X on inputs while ID_isbranch=0 must not affect outputs.
// STRUCTURE
//  Shared package (pipeline_pkg): state encoding ST_RUN/ST_STALL and constants
//   NEED_LOAD_EX=2, NEED_ALU_EX=1, NEED_LOAD_MEM=1, REG_ZERO=5'd0.
//  Sub-module hazard_need (combinational): inputs are one source reg plus the EX/MEM fields;
//   output is a 2-bit need. Instantiated twice (rs, rt). FSM, counter and output decode stay in top.
// TESTING
//  1. rst_n=0 mid-STALL -> outputs immediately pc_write=1, idex_bubble=0; stall_cycles=0.
//  2. beq rs=5, EX lw wbadd=5 -> stall exactly 2 cycles, then RUN. Taken -> ifid_flush=1 one cycle.
//  3. beq rt=7 (ID_usert=1), EX add wbadd=7 -> 1 stall. Same with ID_usert=0 -> 0 stalls.
//  4. jr rs=0, EX regwrite wbadd=0 -> no stall. MEM lw wbadd=rs=9 -> 1 stall.
//  5. EX add wbadd=3, MEM lw wbadd=3, rs=3 -> EX priority, need=1, 1 stall.
//  6. Taken branch during stall -> ifid_flush=0 until hazard clears; stall_cycles advances per stall
//     cycle and saturates (CNT_W=4: holds 15).

Source files
------------

// File: rtl/branch_hazard_ctrl_pkg.sv
// ============================================================================
// Module : pipeline_pkg
// Brief  : Shared state encoding and hazard-need constants for branch_hazard_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    localparam logic [1:0] NEED_NONE     = 2'd0;
    localparam logic [1:0] NEED_LOAD_EX  = 2'd2;
    localparam logic [1:0] NEED_ALU_EX   = 2'd1;
    localparam logic [1:0] NEED_LOAD_MEM = 2'd1;
    localparam logic [4:0] REG_ZERO      = 5'd0;

    function automatic logic [1:0] need_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_hazard_ctrl_hazard_need.sv
// ============================================================================
// Module : hazard_need
// Brief  : Stall cycles one branch source register needs before it reaches a
//          forwarding path into the ID-stage comparator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module hazard_need
    import pipeline_pkg::*;
(
    input  logic [4:0] i_src,
    input  logic [4:0] i_ex_wbadd,
    input  logic       i_ex_regwrite,
    input  logic       i_ex_memread,
    input  logic [4:0] i_mem_wbadd,
    input  logic       i_mem_regwrite,
    input  logic       i_mem_memread,
    output logic [1:0] o_need
);

    logic w_src_nz;
    logic w_ex_hit;
    logic w_mem_hit;

    assign w_src_nz  = (i_src != REG_ZERO);
    assign w_ex_hit  = w_src_nz && i_ex_regwrite  && (i_ex_wbadd  == i_src);
    assign w_mem_hit = w_src_nz && i_mem_regwrite && (i_mem_wbadd == i_src);

    // The youngest producer (EX) holds the live value, so it shadows MEM.
    always_comb begin
        o_need = NEED_NONE;
        if (w_ex_hit) begin
            o_need = i_ex_memread ? NEED_LOAD_EX : NEED_ALU_EX;
        end else if (w_mem_hit && i_mem_memread) begin
            o_need = NEED_LOAD_MEM;
        end
    end

endmodule

`default_nettype wire

// File: rtl/branch_hazard_ctrl.sv
// ============================================================================
// Module : branch_hazard_ctrl
// Brief  : ID-stage stall/flush controller for early branch resolution.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ID_isbranch,
    input  logic             ID_usert,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic [4:0]       EXwbadd,
    input  logic             EXregwrite,
    input  logic             EXmemread,
    input  logic [4:0]       MEMwbadd,
    input  logic             MEMregwrite,
    input  logic             MEMmemread,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_cnt;
    logic [1:0]       w_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cycles;

    logic [1:0] w_need_rs;
    logic [1:0] w_need_rt;
    logic [1:0] w_need;
    logic       w_stall_raw;
    logic       w_stall;

    hazard_need u_need_rs (
        .i_src          (rs),
        .i_ex_wbadd     (EXwbadd),
        .i_ex_regwrite  (EXregwrite),
        .i_ex_memread   (EXmemread),
        .i_mem_wbadd    (MEMwbadd),
        .i_mem_regwrite (MEMregwrite),
        .i_mem_memread  (MEMmemread),
        .o_need         (w_need_rs)
    );

    hazard_need u_need_rt (
        .i_src          (rt),
        .i_ex_wbadd     (EXwbadd),
        .i_ex_regwrite  (EXregwrite),
        .i_ex_memread   (EXmemread),
        .i_mem_wbadd    (MEMwbadd),
        .i_mem_regwrite (MEMregwrite),
        .i_mem_memread  (MEMmemread),
        .o_need         (w_need_rt)
    );

    // Gating on ID_isbranch keeps don't-care operand fields off the outputs.
    always_comb begin
        w_need = NEED_NONE;
        if (ID_isbranch) begin
            w_need = need_max(w_need_rs, ID_usert ? w_need_rt : NEED_NONE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall_raw = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_need != NEED_NONE) begin
                    w_stall_raw = 1'b1;
                    w_cnt_nxt   = w_need - 2'd1;
                    w_state_nxt = (w_need == NEED_LOAD_EX) ? ST_STALL : ST_RUN;
                end
            end
            ST_STALL: begin
                w_stall_raw = 1'b1;
                w_cnt_nxt   = r_cnt - 2'd1;
                if (r_cnt <= 2'd1) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_RUN;
            r_cnt          <= 2'd0;
            r_stall_cycles <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_stall && (r_stall_cycles != C_CNT_MAX)) begin
                r_stall_cycles <= r_stall_cycles + C_CNT_ONE;
            end
        end
    end

    // Reset forces the pipeline-open values even if hazard inputs are live.
    assign w_stall      = rst_n & w_stall_raw;
    assign pc_write     = ~w_stall;
    assign ifid_write   = ~w_stall;
    assign idex_bubble  = w_stall;
    assign ifid_flush   = rst_n & ID_isbranch & branch_taken & ~w_stall;
    assign stall_cycles = r_stall_cycles;

endmodule

`default_nettype wire
